// File: rtl/alu_operand_stage_if.sv
// Decode-to-ALU operand bus: the upstream valid/ready handshake with its
// instruction payload, and the downstream valid/ready handshake with the
// resolved operands.
interface alu_operand_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_alu_op;
   logic [4:0]  in_rs_addr;
   logic [4:0]  in_rt_addr;
   logic [31:0] in_rs_data;
   logic [31:0] in_rt_data;
   logic [31:0] in_imm;
   logic        in_use_imm;
   logic [4:0]  in_shamt;
   logic        in_use_shamt;
   logic [4:0]  in_wb_addr;
   logic        in_wb_en;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_A;
   logic [31:0] out_B;
   logic [11:0] out_alu_op;
   logic [4:0]  out_wb_addr;
   logic        out_wb_en;
   logic        out_op_err;

   // Environment side: issues instructions and consumes operands.
   modport master (
      output in_valid, in_alu_op, in_rs_addr, in_rt_addr, in_rs_data, in_rt_data,
             in_imm, in_use_imm, in_shamt, in_use_shamt, in_wb_addr, in_wb_en,
             out_ready,
      input  in_ready, out_valid, out_A, out_B, out_alu_op, out_wb_addr,
             out_wb_en, out_op_err
   );

   // Stage side.
   modport slave (
      input  in_valid, in_alu_op, in_rs_addr, in_rt_addr, in_rs_data, in_rt_data,
             in_imm, in_use_imm, in_shamt, in_use_shamt, in_wb_addr, in_wb_en,
             out_ready,
      output in_ready, out_valid, out_A, out_B, out_alu_op, out_wb_addr,
             out_wb_en, out_op_err
   );
endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand stage: one-entry skid-free register between decode and the ALU.
// Resolves rs/rt through EX/WB forwarding, muxes in immediate / shift amount,
// stalls decode on a pending EX result, and counts stall cycles.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_EMPTY | no operation held, out_valid = 0
// ST_FULL  | one resolved operation held, out_valid = 1
module alu_operand_stage (
   input  logic                      clk,
   input  logic                      rst,
   alu_operand_stage_if.slave        bus,
   input  logic                      ex_fwd_en,
   input  logic [4:0]                ex_fwd_addr,
   input  logic [31:0]               ex_fwd_data,
   input  logic                      ex_fwd_pending,
   input  logic                      wb_fwd_en,
   input  logic [4:0]                wb_fwd_addr,
   input  logic [31:0]               wb_fwd_data,
   input  logic                      flush,
   output logic [15:0]               stall_cnt
);

   typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [11:0] alu_op_q, alu_op_d;
   logic [4:0]  wb_addr_q, wb_addr_d;
   logic        wb_en_q, wb_en_d;
   logic        op_err_q, op_err_d;
   logic [15:0] stall_q, stall_d;

   logic [31:0] rs_res;
   logic [31:0] rt_res;
   logic        rs_used;
   logic        rt_used;
   logic        hazard;
   logic        out_valid;
   logic        in_ready;
   logic        capture;
   logic        stall_event;

   assign out_valid = (state_q == ST_FULL);

   // Source rs: r0 reads as zero, then EX forward (only once its result exists), then WB, then register file.
   always_comb begin
      rs_res = bus.in_rs_data;
      if (bus.in_rs_addr == 5'd0) begin
         rs_res = 32'd0;
      end else if (ex_fwd_en && !ex_fwd_pending && (ex_fwd_addr == bus.in_rs_addr)) begin
         rs_res = ex_fwd_data;
      end else if (wb_fwd_en && (wb_fwd_addr == bus.in_rs_addr)) begin
         rs_res = wb_fwd_data;
      end
   end

   // Source rt: same priority chain as rs.
   always_comb begin
      rt_res = bus.in_rt_data;
      if (bus.in_rt_addr == 5'd0) begin
         rt_res = 32'd0;
      end else if (ex_fwd_en && !ex_fwd_pending && (ex_fwd_addr == bus.in_rt_addr)) begin
         rt_res = ex_fwd_data;
      end else if (wb_fwd_en && (wb_fwd_addr == bus.in_rt_addr)) begin
         rt_res = wb_fwd_data;
      end
   end

   // Load-use hazard: a source actually consumed by this op waits on an EX result still in flight.
   // Shift ops take rt as the shifted value, so use_shamt forces rt into use regardless of use_imm.
   always_comb begin
      rs_used = !bus.in_use_shamt;
      rt_used = !bus.in_use_imm || bus.in_use_shamt;
      hazard  = bus.in_valid && ex_fwd_en && ex_fwd_pending && (ex_fwd_addr != 5'd0) &&
                ((rs_used && (ex_fwd_addr == bus.in_rs_addr)) ||
                 (rt_used && (ex_fwd_addr == bus.in_rt_addr)));
   end

   assign in_ready = (!out_valid || bus.out_ready) && !hazard;
   assign capture  = bus.in_valid && in_ready;

   // Stalls: decode blocked by a hazard, or an offered op blocked by a back-pressured held entry.
   assign stall_event = hazard || (out_valid && !bus.out_ready && bus.in_valid);

   // Next state, payload load and stall counter; flush beats both capture and drain.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      alu_op_d  = alu_op_q;
      wb_addr_d = wb_addr_q;
      wb_en_d   = wb_en_q;
      op_err_d  = op_err_q;
      stall_d   = stall_q;

      case (state_q)
         ST_EMPTY: begin
            if (!flush && capture) begin
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (flush) begin
               state_d = ST_EMPTY;
            end else if (!capture && bus.out_ready) begin
               state_d = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      if (capture && !flush) begin
         a_d       = bus.in_use_shamt ? {27'd0, bus.in_shamt} : rs_res;
         b_d       = (bus.in_use_imm && !bus.in_use_shamt) ? bus.in_imm : rt_res;
         alu_op_d  = bus.in_alu_op;
         wb_addr_d = bus.in_wb_addr;
         wb_en_d   = bus.in_wb_en && (bus.in_wb_addr != 5'd0);
         op_err_d  = ($countones(bus.in_alu_op) != 1);
      end

      if (stall_event && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   // State and payload registers; reset discards any held entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_EMPTY;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         alu_op_q  <= 12'd0;
         wb_addr_q <= 5'd0;
         wb_en_q   <= 1'b0;
         op_err_q  <= 1'b0;
         stall_q   <= 16'd0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         alu_op_q  <= alu_op_d;
         wb_addr_q <= wb_addr_d;
         wb_en_q   <= wb_en_d;
         op_err_q  <= op_err_d;
         stall_q   <= stall_d;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid;
   assign bus.out_A       = a_q;
   assign bus.out_B       = b_q;
   assign bus.out_alu_op  = alu_op_q;
   assign bus.out_wb_addr = wb_addr_q;
   assign bus.out_wb_en   = wb_en_q;
   assign bus.out_op_err  = op_err_q;
   assign stall_cnt       = stall_q;

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_valid in 1, in_ready out 1  upstream (decode) handshake.
REQ-004 SHALL have ports: in_alu_op in 12, one-hot ALU control; in_rs_addr, in_rt_addr in 5 each; in_rs_data, in_rt_data in 32 each (register-file read data).
REQ-005 SHALL have ports: in_imm in 32, pre-extended immediate; in_use_imm in 1; in_shamt in 5; in_use_shamt in 1; in_wb_addr in 5; in_wb_en in 1.
REQ-006 SHALL have ports: ex_fwd_en in 1, ex_fwd_addr in 5, ex_fwd_data in 32, ex_fwd_pending in 1 (EX result not yet valid, e.g. load).
REQ-007 SHALL have ports: wb_fwd_en in 1, wb_fwd_addr in 5, wb_fwd_data in 32.
REQ-008 SHALL have ports: flush in 1  discard held operation.
REQ-009 SHALL have ports: out_valid out 1, out_ready in 1  downstream (ALU stage) handshake.
REQ-010 SHALL have ports: out_A out 32, out_B out 32, out_alu_op out 12, out_wb_addr out 5, out_wb_en out 1, out_op_err out 1, stall_cnt out 16.

Function
REQ-011 SHALL hold one entry; states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-012 SHALL drive in_ready = (~out_valid | out_ready) & ~hazard, combinationally.
REQ-013 SHALL capture inputs on the edge where in_valid & in_ready; result visible at outputs next cycle (latency 1).
REQ-014 SHALL transition EMPTY->FULL on capture; FULL->EMPTY when out_ready & no capture; FULL->FULL on simultaneous drain and capture (new data replaces old, no bubble).
REQ-015 SHALL keep all out_* stable while out_valid & ~out_ready.
REQ-016 SHALL resolve each source operand: address 0 -> 0; else ex_fwd match (en & addr equal & ~pending) -> ex_fwd_data; else wb_fwd match -> wb_fwd_data; else register-file data. EX has priority over WB.
REQ-017 SHALL assert hazard when in_valid & ex_fwd_en & ex_fwd_pending & ex_fwd_addr!=0 & ex_fwd_addr equals a used source (rs when not use_shamt; rt when not use_imm or when use_shamt).
REQ-018 SHALL select out_A = {27'b0, shamt} when in_use_shamt, else resolved rs.
REQ-019 SHALL select out_B = in_imm when in_use_imm & ~in_use_shamt, else resolved rt; use_shamt overrides use_imm.
REQ-020 SHALL register out_op_err = 1 when captured in_alu_op is not exactly one-hot (zero or multiple bits); out_alu_op is passed unchanged.
REQ-021 SHALL clear out_wb_en to 0 when captured in_wb_addr is 0.
REQ-022 SHALL on flush clear out_valid next cycle; flush dominates same-cycle capture and drain; in_ready unaffected by flush.
REQ-023 SHALL increment stall_cnt each cycle hazard=1 or (out_valid & ~out_ready & in_valid); saturate at 16'hFFFF, no wrap.

Reset
REQ-024 SHALL on rst: out_valid=0, out_A=0, out_B=0, out_alu_op=0, out_wb_addr=0, out_wb_en=0, out_op_err=0, stall_cnt=0.
REQ-025 SHALL treat rst mid-operation as dominating capture, drain and flush; held entry lost.
REQ-026 SHALL keep in_ready combinational during reset per REQ-012 (out_valid=0 after reset edge).

Verification
REQ-027 ADD r3,r1,r2, rs_data=5, rt_data=7, no forwarding, out_ready=1 -> next cycle out_valid=1, A=5, B=7, alu_op=12'h001.
REQ-028 rs=r4 with ex_fwd(r4,0x10) and wb_fwd(r4,0x20), rs_data=0x30 -> A=0x10; same with ex_fwd_en=0 -> A=0x20; rs=r0 with both fwd addr 0 -> A=0.
REQ-029 SLL shamt=3, use_shamt=1, use_imm=1, rt_data=0x1 -> A=0x3, B=0x1; ALU downstream yields 0x8.
REQ-030 ex_fwd_pending=1 for r5, incoming rs=r5 -> in_ready=0, no capture, stall_cnt+1 per cycle; pending drops -> capture, A=ex_fwd_data.
REQ-031 FULL with out_ready=0 for 3 cycles, in_valid=1 -> outputs unchanged, stall_cnt=3; then out_ready=1 and in_valid=1 same cycle -> new entry next cycle, out_valid stays 1.
REQ-032 alu_op=12'h003 -> out_op_err=1; flush with in_valid&in_ready same cycle -> out_valid=0 next cycle; rst with stall_cnt=0xFFFF -> stall_cnt=0.
